window_register_file: RTL
=========================

# window_register_file

Windowed general-purpose register file for the multicycle MIPS-variant datapath. It sits directly downstream of the ALU controller and consumes its `WinEn` strobe, plus the low two `func` bits, to switch the active register window. It maps 3-bit logical register numbers onto a circular bank of 24 physical registers. It supplies the two ALU source operands and accepts the write-back result.

## Interface
- `WIDTH`, 16, data width of every register and data port
- `clk`  in  1  system clock, all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `WinEn`  in  1  window-switch strobe from the ALU controller (high for wnd0..wnd3)
- `WndSel`  in  2  target window, driven from `func[1:0]`; sampled only when `WinEn`=1
- `RegWrite`  in  1  write enable for the write port
- `ReadReg1`  in  3  logical source register A
- `ReadReg2`  in  3  logical source register B
- `WriteReg`  in  3  logical destination register
- `WriteData`  in  WIDTH  write-back value
- `ReadData1`  out  WIDTH  contents of logical `ReadReg1` in the current window
- `ReadData2`  out  WIDTH  contents of logical `ReadReg2` in the current window
- `CurWnd`  out  2  current window pointer, for debug and status

## Operation
- 4 windows (0..3), each exposing logical registers R0..R7. The window stride is 6, so adjacent windows overlap by 2 registers.
- Mapping: physical index = (CurWnd*6 + r) mod 24.
  - Logical R6/R7 of window w alias logical R0/R1 of window (w+1) mod 4.
  - Window 3 R6/R7 wrap to physical 0/1, which are window 0 R0/R1.
- No hardwired-zero register; every logical register is writable.
- Reads are combinational from the current `CurWnd`, `ReadReg1` and `ReadReg2`. There is no write-to-read bypass.
- Write: on a rising edge with `RegWrite`=1, physical[(CurWnd*6 + WriteReg) mod 24] <= `WriteData`.
- Window switch: on a rising edge with `WinEn`=1, `CurWnd` <= `WndSel`. Switching to the current window is legal and has no side effects.
- Mod-24 arithmetic: compute in 5 bits; if the sum is ≥ 24, subtract 24. The maximum sum is 18+7=25, so one subtraction suffices.

## Timing
- Reset (asserted at any time, mid-operation included):
  - all 24 physical registers clear to 0
  - `CurWnd` clears to 0
  - `ReadData1` and `ReadData2` therefore read 0
- The block ignores `WinEn` and `RegWrite` while `rst_n` is low. The first active edge is the first rising edge after `rst_n` deasserts.
- Read latency is 0 cycles: outputs follow the addresses and `CurWnd` combinationally.
- A written value is visible on the read ports from the cycle after the write edge.
- A new `CurWnd` takes effect in the cycle after the `WinEn` edge.
- Simultaneous `WinEn` and `RegWrite` on one edge: the write uses the old window and the pointer update happens on the same edge.
- Reading and writing the same register in one cycle returns the old value.
- Two logical addresses that map to the same physical register (overlap aliasing) always return identical data.

## Structure
- Shared package `rf_pkg` holds:
  - `NUM_WND` = 4
  - `WND_STRIDE` = 6
  - `NUM_PHYS` = 24
  - `LREG_W` = 3
  - `WND_W` = 2
  - the window-op `func` encodings 8'b100000xx, shared with the ALU controller
- One sub-module, `wnd_map`: purely combinational. Takes a 2-bit window and a 3-bit logical register and returns a 5-bit physical index.
  - Instantiated three times: read A, read B, write.
- The top level holds the 24×WIDTH register array, the `CurWnd` register and the read muxes.

## Test plan
- Reset check: assert `rst_n`=0 mid-run after several writes, release it, then read R0..R7 in every window. Required: all reads return 0 and `CurWnd`=0.
- Basic write/read: window 0, write R3=16'h1234. Next cycle, `ReadReg1`=3 and `ReadReg2`=3 both return 16'h1234, and other registers stay 0.
- Overlap: window 0, write R6=16'hAAAA. Switch with `WinEn`=1, `WndSel`=1. Required: R0 in window 1 reads 16'hAAAA and R6 in window 1 reads 0.
- Wrap-around: window 3, write R7=16'h5A5A. Switch to window 0. Required: R1 reads 16'h5A5A; physical 1 is hit.
- Simultaneous events: in window 0, assert `WinEn`=1 (`WndSel`=2) and `RegWrite`=1 (R2=16'hBEEF) on the same edge. Required:
  - window 0 R2 = 16'hBEEF
  - window 2 R2 = 0
  - `CurWnd`=2 next cycle
- Same-cycle read/write: in window 1, R4 holds 16'h0001; write R4=16'h0002 while reading R4. Required: read shows 16'h0001 before the edge and 16'h0002 after it.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants for the windowed register file.
// Also holds the window-op func encodings that the ALU controller decodes.
package rf_pkg;

  localparam int unsigned NUM_WND    = 4;
  localparam int unsigned WND_STRIDE = 6;
  localparam int unsigned NUM_PHYS   = 24;
  localparam int unsigned LREG_W     = 3;
  localparam int unsigned WND_W      = 2;
  localparam int unsigned PHYS_W     = 5;

  // func values that raise WinEn; func[1:0] becomes WndSel
  typedef enum logic [7:0] {
    FuncWnd0 = 8'b1000_0000,
    FuncWnd1 = 8'b1000_0001,
    FuncWnd2 = 8'b1000_0010,
    FuncWnd3 = 8'b1000_0011
  } wnd_func_e;

  localparam logic [5:0] FUNC_WND_PREFIX = 6'b10_0000;

endpackage

// File: rtl/window_register_file_wnd_map.sv
// Logical-to-physical register mapping for one window access.
// Physical index = (wnd*6 + lreg) mod 24, with a single conditional subtract.
module wnd_map
  import rf_pkg::*;
(
  input  logic [WND_W-1:0]  i_wnd,
  input  logic [LREG_W-1:0] i_lreg,
  output logic [PHYS_W-1:0] o_phys
);

  logic [PHYS_W-1:0] w_sum;

  // Max sum is 18 + 7 = 25, so one subtraction of 24 covers the wrap
  always_comb begin
    w_sum  = PHYS_W'(i_wnd) * PHYS_W'(WND_STRIDE) + PHYS_W'(i_lreg);
    o_phys = (w_sum >= PHYS_W'(NUM_PHYS)) ? (w_sum - PHYS_W'(NUM_PHYS)) : w_sum;
  end

endmodule

// File: rtl/window_register_file.sv
// Windowed register file: 4 overlapping windows of 8 logical registers over 24 physical.
// Two combinational read ports, one synchronous write port, registered window pointer.
module window_register_file
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              WinEn,
  input  logic [WND_W-1:0]  WndSel,
  input  logic              RegWrite,
  input  logic [LREG_W-1:0] ReadReg1,
  input  logic [LREG_W-1:0] ReadReg2,
  input  logic [LREG_W-1:0] WriteReg,
  input  logic [WIDTH-1:0]  WriteData,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  output logic [WND_W-1:0]  CurWnd
);

  logic [WIDTH-1:0]  r_regs [NUM_PHYS];
  logic [WND_W-1:0]  r_cur_wnd;
  logic [PHYS_W-1:0] w_phys_a;
  logic [PHYS_W-1:0] w_phys_b;
  logic [PHYS_W-1:0] w_phys_w;

  wnd_map u_map_a (
    .i_wnd  (r_cur_wnd),
    .i_lreg (ReadReg1),
    .o_phys (w_phys_a)
  );

  wnd_map u_map_b (
    .i_wnd  (r_cur_wnd),
    .i_lreg (ReadReg2),
    .o_phys (w_phys_b)
  );

  wnd_map u_map_w (
    .i_wnd  (r_cur_wnd),
    .i_lreg (WriteReg),
    .o_phys (w_phys_w)
  );

  // Write address uses the pre-switch window when WinEn and RegWrite coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_PHYS); i++) begin
        r_regs[i] <= '0;
      end
      r_cur_wnd <= '0;
    end else begin
      if (RegWrite) begin
        r_regs[w_phys_w] <= WriteData;
      end
      if (WinEn) begin
        r_cur_wnd <= WndSel;
      end
    end
  end

  assign ReadData1 = r_regs[w_phys_a];
  assign ReadData2 = r_regs[w_phys_b];
  assign CurWnd    = r_cur_wnd;

endmodule
